// File: rtl/mostra_sequencia.sv
// Steps through sequence memory entries 0..limite: each entry is shown on leds
// for T_ON cycles, followed by T_OFF blank cycles; pronto pulses once at the end.
module mostra_sequencia #(
  parameter int T_ON  = 500,
  parameter int T_OFF = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  output logic [3:0] endereco,
  input  logic [3:0] dado,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    MOSTRA  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam logic [15:0] TON_LAST  = 16'(T_ON - 1);
  localparam logic [15:0] TOFF_LAST = 16'(T_OFF - 1);

  estado_t     estado_q, estado_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  endereco_q, endereco_d;
  logic [3:0]  limite_q, limite_d;
  logic        ocupado_q, ocupado_d;
  logic        pronto_q, pronto_d;

  always_comb begin
    estado_d   = estado_q;
    timer_d    = timer_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_d   = PREPARA;
          endereco_d = 4'd0;
          timer_d    = 16'd0;
        end
      end
      PREPARA: begin
        limite_d   = limite;
        endereco_d = 4'd0;
        timer_d    = 16'd0;
        estado_d   = MOSTRA;
      end
      MOSTRA: begin
        if (timer_q == TON_LAST) begin
          timer_d  = 16'd0;
          estado_d = APAGA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      APAGA: begin
        if (timer_q == TOFF_LAST) begin
          timer_d  = 16'd0;
          estado_d = (endereco_q == limite_q) ? FIM : PROXIMO;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      PROXIMO: begin
        // Only reached when endereco_q < limite_q, so this never wraps past 15
        endereco_d = endereco_q + 4'd1;
        estado_d   = MOSTRA;
      end
      FIM:     estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase

    ocupado_d = (estado_d == PREPARA) || (estado_d == MOSTRA) ||
                (estado_d == APAGA)   || (estado_d == PROXIMO);
    pronto_d  = (estado_d == FIM);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      timer_q    <= 16'd0;
      endereco_q <= 4'd0;
      limite_q   <= 4'd0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      timer_q    <= timer_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
    end
  end

  // leds follows the memory word addressed by the registered endereco
  assign leds      = (estado_q == MOSTRA) ? dado : 4'd0;
  assign endereco  = endereco_q;
  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_mostra_sequencia.sv
// Directed bench for mostra_sequencia with T_ON=4, T_OFF=2 and a fixed 16x4 memory.
module tb_mostra_sequencia;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] endereco;
  logic [3:0] dado;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  int n_checks = 0;
  int n_pass   = 0;
  int pronto_cnt = 0;

  always #5 clock = ~clock;

  assign dado = mem[endereco];

  mostra_sequencia #(.T_ON(4), .T_OFF(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .limite   (limite),
    .endereco (endereco),
    .dado     (dado),
    .leds     (leds),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  always @(negedge clock) if (pronto === 1'b1) pronto_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Checks {db_estado, leds, ocupado, pronto} (and endereco when addr >= 0), then advances one cycle
  task automatic expect_st(input string tag, input int db, input int ld, input bit oc,
                           input bit pr, input int addr, input bit wig);
    check(tag, {db_estado, leds, ocupado, pronto}, {db[3:0], ld[3:0], oc, pr});
    if (addr >= 0) check({tag, "_addr"}, endereco, addr);
    if (wig) iniciar = ~iniciar;
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {db_estado, leds, ocupado, pronto}, 10'd0);
  endtask

  // Starts a presentation from an INICIAL sample point and returns at the next INICIAL sample
  task automatic run(input int lim, input bit wig, input bit hold);
    int pc0;
    pc0 = pronto_cnt;
    limite  = 4'(lim);
    iniciar = 1'b1;
    @(negedge clock);
    if (!hold) iniciar = 1'b0;
    expect_st("prepara", 1, 0, 1, 0, -1, wig);
    if (wig) limite = 4'hF;
    for (int k = 0; k <= lim; k++) begin
      for (int t = 0; t < 4; t++) expect_st("mostra", 2, int'(mem[k]), 1, 0, k, wig);
      for (int t = 0; t < 2; t++) expect_st("apaga", 3, 0, 1, 0, k, wig);
      if (k < lim) expect_st("proximo", 4, 0, 1, 0, -1, wig);
    end
    if (!hold) iniciar = 1'b0;
    expect_st("fim", 5, 0, 0, 1, -1, 1'b0);
    check("inicial", {db_estado, leds, ocupado, pronto}, 10'd0);
    check("pronto_count", pronto_cnt, pc0 + 1);
    $display("run limite=%0d wiggle=%0d hold=%0d done at %0t", lim, wig, hold, $time);
  endtask

  initial begin
    int pc0;
    mem = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
            4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};
    reset   = 1'b0;
    iniciar = 1'b0;
    limite  = 4'd0;
    @(negedge clock);
    @(negedge clock);
    check_idle("reset_outputs");
    check("reset_addr", endereco, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_idle("idle");
    end
    $display("reset/idle phase done at %0t", $time);

    run(3, 1'b0, 1'b0);
    run(3, 1'b1, 1'b0);
    run(15, 1'b0, 1'b0);

    // Abort during MOSTRA of entry 2: PREPARA + 2*(6+1) cycles after start
    pc0 = pronto_cnt;
    limite  = 4'd3;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (15) @(negedge clock);
    check("abort_pre_state", db_estado, 2);
    check("abort_pre_addr", endereco, 2);
    check("abort_pre_leds", leds, 4);
    reset = 1'b0;
    @(negedge clock);
    check_idle("abort_reset");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_idle("abort_idle");
    end
    check("abort_no_pronto", pronto_cnt, pc0);
    $display("abort phase done at %0t", $time);

    run(0, 1'b0, 1'b1);
    run(0, 1'b0, 1'b1);
    iniciar = 1'b0;
    @(negedge clock);
    check_idle("after_b2b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mostra_sequencia.md
MOSTRA_SEQUENCIA -- requirements
Module: mostra_sequencia

Interface
REQ-001 Parameter T_ON, default 500, meaning the number of clock cycles each stored value is shown on leds (500 ms at 1 kHz).
REQ-002 Parameter T_OFF, default 250, meaning the number of blank clock cycles after each shown value.
REQ-003 Port clock, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, meaning the synchronous, active-low reset; it is sampled only on the rising edge of clock.
REQ-005 Port iniciar, input, 1 bit, meaning the start request; level-sampled.
REQ-006 Port limite, input, 4 bits, meaning the index of the last entry to show; the block shows entries 0..limite.
REQ-007 Port endereco, output, 4 bits, meaning the read address to the 16x4 sequence memory.
REQ-008 Port dado, input, 4 bits, meaning the memory word at endereco; combinational read with no latency.
REQ-009 Port leds, output, 4 bits, meaning the displayed value.
REQ-010 Port ocupado, output, 1 bit, meaning a presentation is in progress.
REQ-011 Port pronto, output, 1 bit, meaning a one-cycle pulse marking the end of a presentation.
REQ-012 Port db_estado, output, 4 bits, meaning the current state code, for the 7-segment debug display.

Function
REQ-013 The FSM SHALL use these state codes: INICIAL=0, PREPARA=1, MOSTRA=2, APAGA=3, PROXIMO=4, FIM=5; any other code SHALL go to INICIAL on the next cycle.
REQ-014 INICIAL: if iniciar=1 at the edge, go to PREPARA; otherwise stay in INICIAL.
REQ-015 PREPARA: lasts 1 cycle; endereco=0; timer=0; limite is latched into an internal register; go to MOSTRA.
REQ-016 MOSTRA: leds=dado; the timer counts 0..T_ON-1; after exactly T_ON cycles, clear the timer and go to APAGA.
REQ-017 APAGA: leds=0000; the timer counts 0..T_OFF-1; after exactly T_OFF cycles, go to FIM if endereco equals latched limite, else go to PROXIMO.
REQ-018 PROXIMO: lasts 1 cycle; endereco increments by 1; leds=0000; go to MOSTRA.
REQ-019 FIM: lasts 1 cycle; pronto=1; leds=0000; go to INICIAL.
REQ-020 ocupado SHALL be 1 in PREPARA, MOSTRA, APAGA and PROXIMO, and 0 in INICIAL and FIM.
REQ-021 pronto SHALL be 1 only in FIM.
REQ-022 iniciar SHALL be ignored in every state except INICIAL; holding iniciar=1 through FIM restarts the presentation with no idle cycle beyond the one cycle in INICIAL.
REQ-023 Changes to limite while ocupado=1 SHALL have no effect; only the latched value is used.
REQ-024 Boundaries:
- limite=0: show entry 0 only.
- limite=15: show all 16 entries; endereco SHALL never wrap past 15.
REQ-025 Latency:
- Cycles spent in states other than INICIAL and FIM total 1 + (limite+1)*(T_ON+T_OFF) + limite.
- pronto is asserted on the cycle immediately after that interval.
REQ-026 The timer SHALL be 16 bits wide; T_ON and T_OFF SHALL each be in the range 1..65535.
REQ-027 Outputs SHALL be decoded from the registered state and registers only (Moore machine), with no direct combinational path from iniciar.

Reset
REQ-028 With reset=0 at a rising edge:
- state=INICIAL, endereco=0, timer=0, latched limite=0.
- leds=0000, ocupado=0, pronto=0, db_estado=0000.
REQ-029 Reset SHALL take priority over iniciar and SHALL abort a presentation mid-operation from any state, with no pronto pulse.

Verification (T_ON=4, T_OFF=2; memory model 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4)
REQ-030 Reset: reset=0 for 1 cycle, then iniciar=0 for 10 cycles -> db_estado=0, leds=0000, ocupado=0, pronto=0 throughout.
REQ-031 Short run: limite=3, iniciar=1 for 1 cycle -> leds shows 0001,0010,0100,1000, each for 4 cycles separated by 2 blank cycles; pronto pulses once, 1+4*6+3=28 cycles after the start edge.
REQ-032 Full run: limite=15 -> 16 values shown in memory order; endereco is 15 during the last value and never reads 0 again before FIM; pronto pulses once.
REQ-033 Ignored inputs: during the limite=3 run, toggle iniciar and change limite to 15 -> exactly 4 values are shown and the pronto timing is unchanged.
REQ-034 Abort: reset=0 during MOSTRA of entry 2 -> the next cycle has leds=0000, ocupado=0, db_estado=0; no pronto pulse occurs.
REQ-035 Back-to-back: limite=0 with iniciar held at 1 -> a repeating pattern of 1 PREPARA cycle, 4 cycles of leds=0001, 2 APAGA cycles, 1 FIM cycle with pronto=1, and 1 INICIAL cycle, giving a 9-cycle period.
